// File: rtl/tag_allocator_pkg.sv
// Shared definitions for the physical tag allocator: width derivation, the
// tagged-pointer format used on commit ports, and commit-port decoding.
package tag_allocator_pkg;

    typedef enum logic [1:0] {
        CK_IDLE   = 2'd0,
        CK_REPLAY = 2'd1,
        CK_NEWEST = 2'd2,
        CK_OLDER  = 2'd3
    } commit_kind_e;

    function automatic int unsigned tag_w_of(input int unsigned num_tags);
        return $clog2(num_tags);
    endfunction

    function automatic int unsigned cnt_w_of(input int unsigned num_tags);
        return tag_w_of(num_tags) + 1;
    endfunction

    // Tagged pointer: {none_flag, tag}; none_flag=1 means the pointer carries no tag.
    function automatic int unsigned ptr_w_of(input int unsigned num_tags);
        return tag_w_of(num_tags) + 1;
    endfunction

    function automatic commit_kind_e commit_kind(input logic valid, input logic flush,
                                                 input logic newest);
        if (!valid)      return CK_IDLE;
        else if (flush)  return CK_REPLAY;
        else if (newest) return CK_NEWEST;
        else             return CK_OLDER;
    endfunction

endpackage

// File: rtl/priority_pick_n.sv
// Returns the indices of the N lowest set bits of vec, with a valid per slot.
module priority_pick_n #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 6
) (
    input  logic [WIDTH-1:0]   vec,
    output logic [N*IDX_W-1:0] idx_c,
    output logic [N-1:0]       valid_c
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0] seen;

    always_comb begin
        idx_c   = '0;
        valid_c = '0;
        seen    = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (vec[b]) begin
                for (int k = 0; k < N; k++) begin
                    if (seen == CW'(k)) begin
                        idx_c[k*IDX_W +: IDX_W] = IDX_W'(b);
                        valid_c[k]              = 1'b1;
                    end
                end
                seen = seen + CW'(1);
            end
        end
    end

endmodule

// File: rtl/tag_allocator.sv
// Physical tag allocator: tracks speculative-use and committed-mapped bits per
// tag, offers the lowest free tags to issue ports and applies commit updates.
module tag_allocator
    import tag_allocator_pkg::*;
#(
    parameter int unsigned NUM_TAGS   = 64,
    parameter int unsigned NUM_ISSUE  = 4,
    parameter int unsigned NUM_COMMIT = 4,
    localparam int unsigned TAG_W     = tag_w_of(NUM_TAGS),
    localparam int unsigned CNT_W     = cnt_w_of(NUM_TAGS),
    localparam int unsigned PTR_W     = ptr_w_of(NUM_TAGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        IN_mispr,
    input  logic                        IN_mispredFlush,
    input  logic [NUM_ISSUE-1:0]        IN_issueValid,
    output logic [NUM_ISSUE*TAG_W-1:0]  OUT_issueTags,
    output logic [NUM_ISSUE-1:0]        OUT_issueTagsValid,
    input  logic [NUM_COMMIT-1:0]       IN_commitValid,
    input  logic [NUM_COMMIT-1:0]       IN_commitNewest,
    input  logic [NUM_COMMIT*PTR_W-1:0] IN_commitPrevTag,
    input  logic [NUM_COMMIT*PTR_W-1:0] IN_commitTagDst,
    output logic [CNT_W-1:0]            OUT_freeCount,
    output logic [CNT_W-1:0]            OUT_comFreeCount,
    output logic                        OUT_err
);

    logic [NUM_TAGS-1:0]        used, used_n, comm, comm_n;
    logic                       err, err_n;
    logic [NUM_TAGS-1:0]        free_vec;
    logic [NUM_ISSUE*TAG_W-1:0] offer_tag;
    logic [NUM_ISSUE-1:0]       offer_valid;
    logic [PTR_W-1:0]           prev_ptr, dst_ptr;
    logic [TAG_W-1:0]           prev_tag, dst_tag;
    logic [CNT_W-1:0]           free_cnt, com_free_cnt;

    assign free_vec = ~used;

    priority_pick_n #(
        .WIDTH (NUM_TAGS),
        .N     (NUM_ISSUE),
        .IDX_W (TAG_W)
    ) u_pick (
        .vec     (free_vec),
        .idx_c   (offer_tag),
        .valid_c (offer_valid)
    );

    // Next state: mispredict/issue first, then commit ports in ascending order so
    // later ports and all commit writes override earlier updates to the same tag.
    always_comb begin
        used_n   = used;
        comm_n   = comm;
        err_n    = err;
        prev_ptr = '0;
        dst_ptr  = '0;
        prev_tag = '0;
        dst_tag  = '0;

        if (IN_mispr) begin
            used_n = used & comm;
        end else begin
            for (int i = 0; i < NUM_ISSUE; i++) begin
                if (IN_issueValid[i]) begin
                    if (offer_valid[i]) used_n[offer_tag[i*TAG_W +: TAG_W]] = 1'b1;
                    else                err_n = 1'b1;
                end
            end
        end

        for (int j = 0; j < NUM_COMMIT; j++) begin
            prev_ptr = IN_commitPrevTag[j*PTR_W +: PTR_W];
            dst_ptr  = IN_commitTagDst[j*PTR_W +: PTR_W];
            prev_tag = prev_ptr[TAG_W-1:0];
            dst_tag  = dst_ptr[TAG_W-1:0];
            case (commit_kind(IN_commitValid[j], IN_mispredFlush, IN_commitNewest[j]))
                CK_REPLAY: begin
                    if (!IN_mispr && !dst_ptr[TAG_W]) used_n[dst_tag] = 1'b1;
                end
                CK_NEWEST: begin
                    if (!prev_ptr[TAG_W]) begin
                        if (!used[prev_tag]) err_n = 1'b1;
                        used_n[prev_tag] = 1'b0;
                        comm_n[prev_tag] = 1'b0;
                    end
                    if (!dst_ptr[TAG_W]) begin
                        if (comm[dst_tag]) err_n = 1'b1;
                        used_n[dst_tag] = 1'b1;
                        comm_n[dst_tag] = 1'b1;
                    end
                end
                CK_OLDER: begin
                    if (!dst_ptr[TAG_W]) begin
                        if (!used[dst_tag]) err_n = 1'b1;
                        used_n[dst_tag] = 1'b0;
                        comm_n[dst_tag] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used <= '0;
            comm <= '0;
            err  <= 1'b0;
        end else begin
            used <= used_n;
            comm <= comm_n;
            err  <= err_n;
        end
    end

    // Counts are population counts of registered state.
    always_comb begin
        free_cnt     = '0;
        com_free_cnt = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            free_cnt     = free_cnt + CNT_W'(~used[t]);
            com_free_cnt = com_free_cnt + CNT_W'(~comm[t]);
        end
    end

    assign OUT_issueTags      = offer_tag;
    assign OUT_issueTagsValid = offer_valid;
    assign OUT_freeCount      = free_cnt;
    assign OUT_comFreeCount   = com_free_cnt;
    assign OUT_err            = err;

endmodule

// File: tb/tb_tag_allocator.sv
// Directed testbench for tag_allocator with default parameters (64 tags, 4 ports).
module tb_tag_allocator;

    localparam int unsigned NT = 64;
    localparam int unsigned NI = 4;
    localparam int unsigned NC = 4;
    localparam int unsigned TW = 6;
    localparam int unsigned PW = 7;
    localparam logic [PW-1:0] NONE = 7'h40;

    logic            clk = 1'b0;
    logic            rst;
    logic            mispr;
    logic            flush;
    logic [NI-1:0]   issue_valid;
    logic [NI*TW-1:0] issue_tags;
    logic [NI-1:0]   issue_tags_valid;
    logic [NC-1:0]   commit_valid;
    logic [NC-1:0]   commit_newest;
    logic [NC*PW-1:0] commit_prev;
    logic [NC*PW-1:0] commit_dst;
    logic [TW:0]     free_count;
    logic [TW:0]     com_free_count;
    logic            err;

    int tests = 0;
    int fails = 0;

    tag_allocator #(.NUM_TAGS(NT), .NUM_ISSUE(NI), .NUM_COMMIT(NC)) dut (
        .clk                (clk),
        .rst                (rst),
        .IN_mispr           (mispr),
        .IN_mispredFlush    (flush),
        .IN_issueValid      (issue_valid),
        .OUT_issueTags      (issue_tags),
        .OUT_issueTagsValid (issue_tags_valid),
        .IN_commitValid     (commit_valid),
        .IN_commitNewest    (commit_newest),
        .IN_commitPrevTag   (commit_prev),
        .IN_commitTagDst    (commit_dst),
        .OUT_freeCount      (free_count),
        .OUT_comFreeCount   (com_free_count),
        .OUT_err            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        mispr         = 1'b0;
        flush         = 1'b0;
        issue_valid   = '0;
        commit_valid  = '0;
        commit_newest = '0;
        commit_prev   = {NC{NONE}};
        commit_dst    = {NC{NONE}};
    endtask

    task automatic set_commit(input int p, input logic newest, input logic [PW-1:0] prev,
                              input logic [PW-1:0] dst);
        commit_valid[p]         = 1'b1;
        commit_newest[p]        = newest;
        commit_prev[p*PW +: PW] = prev;
        commit_dst[p*PW +: PW]  = dst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        issue_valid = 4'hf;
        mispr = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (issue_tags !== {6'd3, 6'd2, 6'd1, 6'd0}) begin
            fails++; $display("FAIL reset_offers: got %h expected %h", issue_tags, {6'd3, 6'd2, 6'd1, 6'd0});
        end
        tests++;
        if (issue_tags_valid !== 4'hf) begin
            fails++; $display("FAIL reset_valids: got %b expected 1111", issue_tags_valid);
        end
        tests++;
        if (free_count !== 7'd64) begin
            fails++; $display("FAIL reset_free: got %0d expected 64", free_count);
        end
        tests++;
        if (com_free_count !== 7'd64) begin
            fails++; $display("FAIL reset_comfree: got %0d expected 64", com_free_count);
        end
        tests++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL reset_err: got %b expected 0", err);
        end
    endtask

    task automatic test_fill();
        do_reset();
        issue_valid = 4'hf;
        tick();
        tests++;
        if (issue_tags !== {6'd7, 6'd6, 6'd5, 6'd4} || free_count !== 7'd60) begin
            fails++; $display("FAIL fill_first: tags %h free %0d expected 07060504 offers free 60",
                              issue_tags, free_count);
        end
        for (int c = 1; c < 16; c++) begin
            issue_valid = 4'hf;
            tick();
        end
        tests++;
        if (free_count !== 7'd0 || issue_tags_valid !== 4'b0000) begin
            fails++; $display("FAIL fill_full: free %0d valids %b expected 0 / 0000", free_count, issue_tags_valid);
        end
        tests++;
        if (err !== 1'b0 || com_free_count !== 7'd64) begin
            fails++; $display("FAIL fill_noerr: err %b comfree %0d expected 0 / 64", err, com_free_count);
        end
        issue_valid = 4'b0001;
        tick();
        tests++;
        if (err !== 1'b1) begin
            fails++; $display("FAIL issue_when_full_err: got %b expected 1", err);
        end
        tests++;
        if (free_count !== 7'd0 || com_free_count !== 7'd64) begin
            fails++; $display("FAIL issue_when_full_state: free %0d comfree %0d expected 0 / 64",
                              free_count, com_free_count);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        issue_valid = 4'hf;
        tick();
        set_commit(0, 1'b1, NONE, 7'd0);
        tick();
        tests++;
        if (free_count !== 7'd60 || com_free_count !== 7'd63) begin
            fails++; $display("FAIL commit_newest: free %0d comfree %0d expected 60 / 63", free_count, com_free_count);
        end
        mispr = 1'b1;
        issue_valid = 4'hf;
        tick();
        tests++;
        if (free_count !== 7'd63 || com_free_count !== 7'd63) begin
            fails++; $display("FAIL mispredict_counts: free %0d comfree %0d expected 63 / 63", free_count, com_free_count);
        end
        tests++;
        if (issue_tags !== {6'd4, 6'd3, 6'd2, 6'd1} || err !== 1'b0) begin
            fails++; $display("FAIL mispredict_offers: tags %h err %b expected 04030201 / 0", issue_tags, err);
        end
    endtask

    // Continues from test_mispredict: tag 0 held and committed.
    task automatic test_commit_vs_mispr();
        mispr = 1'b1;
        set_commit(0, 1'b1, 7'd0, 7'd5);
        tick();
        tests++;
        if (free_count !== 7'd63 || com_free_count !== 7'd63) begin
            fails++; $display("FAIL commit_over_mispr_counts: free %0d comfree %0d expected 63 / 63",
                              free_count, com_free_count);
        end
        tests++;
        if (issue_tags !== {6'd3, 6'd2, 6'd1, 6'd0} || err !== 1'b0) begin
            fails++; $display("FAIL commit_over_mispr_offers: tags %h err %b expected 03020100 / 0", issue_tags, err);
        end
    endtask

    // Continues with tag 5 held and committed.
    task automatic test_flush_replay();
        flush = 1'b1;
        set_commit(0, 1'b0, NONE, 7'd7);
        tick();
        tests++;
        if (free_count !== 7'd62 || com_free_count !== 7'd63 || err !== 1'b0) begin
            fails++; $display("FAIL flush_replay: free %0d comfree %0d err %b expected 62 / 63 / 0",
                              free_count, com_free_count, err);
        end
        flush = 1'b1;
        mispr = 1'b1;
        set_commit(0, 1'b0, NONE, 7'd8);
        tick();
        tests++;
        if (free_count !== 7'd63 || com_free_count !== 7'd63) begin
            fails++; $display("FAIL flush_during_mispr: free %0d comfree %0d expected 63 / 63",
                              free_count, com_free_count);
        end
    endtask

    task automatic test_double_free();
        set_commit(0, 1'b0, NONE, 7'd9);
        tick();
        tests++;
        if (err !== 1'b1 || free_count !== 7'd63) begin
            fails++; $display("FAIL double_free: err %b free %0d expected 1 / 63", err, free_count);
        end
        repeat (3) tick();
        tests++;
        if (err !== 1'b1) begin
            fails++; $display("FAIL err_sticky: got %b expected 1", err);
        end
        do_reset();
        tests++;
        if (err !== 1'b0 || free_count !== 7'd64 || com_free_count !== 7'd64) begin
            fails++; $display("FAIL reset_clears: err %b free %0d comfree %0d expected 0 / 64 / 64",
                              err, free_count, com_free_count);
        end
    endtask

    task automatic test_port_priority();
        do_reset();
        issue_valid = 4'hf;
        tick();
        set_commit(0, 1'b0, NONE, 7'd2);
        set_commit(1, 1'b1, NONE, 7'd2);
        tick();
        tests++;
        if (free_count !== 7'd60 || com_free_count !== 7'd63 || err !== 1'b0) begin
            fails++; $display("FAIL port_priority: free %0d comfree %0d err %b expected 60 / 63 / 0",
                              free_count, com_free_count, err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue_valid = 4'b0101;
        tick();
        tests++;
        if (issue_tags !== {6'd5, 6'd4, 6'd3, 6'd1} || free_count !== 7'd62) begin
            fails++; $display("FAIL partial_issue: tags %h free %0d expected 05040301 / 62", issue_tags, free_count);
        end
        issue_valid = 4'b1111;
        tick();
        tests++;
        if (issue_tags !== {6'd9, 6'd8, 6'd7, 6'd6} || free_count !== 7'd58) begin
            fails++; $display("FAIL back_to_back: tags %h free %0d expected 09080706 / 58", issue_tags, free_count);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_mispredict();
        test_commit_vs_mispr();
        test_flush_replay();
        test_double_free();
        test_port_priority();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
